// File: rtl/soc_evt_bus_tx.sv
// rtl/soc_evt_bus_tx.sv - round-robin multi-channel event transmitter with toggle-token slot buffer
//
// Optional build macro: SOC_EVT_BUS_TX_STALL_CNT_EN adds stall_cnt_o.
//
// Ports:
//   clk_i        SoC clock
//   rst_ni       synchronous active-low reset
//   evt_valid_i  per-channel event request
//   evt_data_i   per-channel event ID, channel c at [c*EVNT_WIDTH +: EVNT_WIDTH]
//   evt_ready_o  per-channel accept, one-hot or zero
//   events_wt_o  per-slot write-token toggles
//   events_rp_i  per-slot read-pointer toggles from the reader (may be asynchronous)
//   events_da_o  slot data, slot s at [s*EVNT_WIDTH +: EVNT_WIDTH]
//   level_o      number of occupied slots
//   full_o       slot at the write index is occupied
//   empty_o      no slot occupied
//   stall_cnt_o  saturating count of cycles with a request blocked by full (optional)
module soc_evt_bus_tx #(
    parameter int N_CHAN       = 4,
    parameter int EVNT_WIDTH   = 8,
    parameter int BUFFER_WIDTH = 8,
    parameter int LVL_W        = $clog2(BUFFER_WIDTH + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [N_CHAN-1:0]                  evt_valid_i,
    input  logic [N_CHAN*EVNT_WIDTH-1:0]       evt_data_i,
    output logic [N_CHAN-1:0]                  evt_ready_o,
    output logic [BUFFER_WIDTH-1:0]            events_wt_o,
    input  logic [BUFFER_WIDTH-1:0]            events_rp_i,
    output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_o,
    output logic [LVL_W-1:0]                   level_o,
    output logic                               full_o,
    output logic                               empty_o
`ifdef SOC_EVT_BUS_TX_STALL_CNT_EN
    ,
    output logic [15:0]                        stall_cnt_o
`endif
);

    localparam int IDX_W = $clog2(BUFFER_WIDTH);
    localparam int CH_W  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_WIDTH - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CHAN - 1);
    localparam logic [CH_W:0]    N_CH_EXT = (CH_W + 1)'(N_CHAN);

    // Buffer state
    logic [BUFFER_WIDTH-1:0]                  wt_q, wt_d;
    logic [BUFFER_WIDTH-1:0][EVNT_WIDTH-1:0] da_q, da_d;
    logic [IDX_W-1:0]                         wr_idx_q, wr_idx_d;
    logic [CH_W-1:0]                          rr_ptr_q, rr_ptr_d;

    // Two-flop synchroniser for the reader's toggle pointers
    logic [BUFFER_WIDTH-1:0]                  rp_meta_q;
    logic [BUFFER_WIDTH-1:0]                  rp_sync_q;

    // Occupancy
    logic [BUFFER_WIDTH-1:0]                  occ;
    logic [LVL_W-1:0]                         level;
    logic                                     full;

    // Arbitration
    logic                                     grant_vld;
    logic [CH_W-1:0]                          grant_idx;
    logic [CH_W:0]                            cand;
    logic [EVNT_WIDTH-1:0]                    grant_data;

    // A slot is occupied while its write token differs from the reader's pointer.
    assign occ  = wt_q ^ rp_sync_q;
    assign full = occ[wr_idx_q];

    always_comb begin
        level = '0;
        for (int s = 0; s < BUFFER_WIDTH; s++) begin
            level = level + LVL_W'(occ[s]);
        end
    end

    // Round-robin search starting at rr_ptr_q, wrapping at N_CHAN.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            cand = {1'b0, rr_ptr_q} + (CH_W + 1)'(k);
            if (cand >= N_CH_EXT) begin
                cand = cand - N_CH_EXT;
            end
            if (!grant_vld && evt_valid_i[cand[CH_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[CH_W-1:0];
            end
        end
        // A full write slot blocks every channel; nothing is latched.
        if (full) begin
            grant_vld = 1'b0;
        end
    end

    assign grant_data = evt_data_i[grant_idx*EVNT_WIDTH +: EVNT_WIDTH];

    // Next-state: an accept writes data and flips the token on the same edge.
    always_comb begin
        wt_d     = wt_q;
        da_d     = da_q;
        wr_idx_d = wr_idx_q;
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            da_d[wr_idx_q] = grant_data;
            wt_d[wr_idx_q] = ~wt_q[wr_idx_q];
            wr_idx_d       = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + 1'b1;
            rr_ptr_d       = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef SOC_EVT_BUS_TX_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((|evt_valid_i) && full && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wt_q      <= '0;
            da_q      <= '0;
            wr_idx_q  <= '0;
            rr_ptr_q  <= '0;
            rp_meta_q <= '0;
            rp_sync_q <= '0;
        end else begin
            wt_q      <= wt_d;
            da_q      <= da_d;
            wr_idx_q  <= wr_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            rp_meta_q <= events_rp_i;
            rp_sync_q <= rp_meta_q;
        end
    end

    assign evt_ready_o = grant_vld ? (N_CHAN'(1) << grant_idx) : '0;
    assign events_wt_o = wt_q;
    assign events_da_o = da_q;
    assign level_o     = level;
    assign full_o      = full;
    assign empty_o     = (level == '0);

endmodule

// File: tb/tb_soc_evt_bus_tx.sv
// tb/tb_soc_evt_bus_tx.sv - directed table-driven bench for soc_evt_bus_tx
module tb_soc_evt_bus_tx;

    logic        clk;
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  ready;
    logic [7:0]  wt;
    logic [7:0]  rp;
    logic [63:0] da;
    logic [3:0]  level;
    logic        full;
    logic        empty;
`ifdef SOC_EVT_BUS_TX_STALL_CNT_EN
    logic [15:0] stall;
`endif

    int total = 0;
    int bad   = 0;

    soc_evt_bus_tx #(
        .N_CHAN      (4),
        .EVNT_WIDTH  (8),
        .BUFFER_WIDTH(8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .evt_valid_i(valid),
        .evt_data_i (data),
        .evt_ready_o(ready),
        .events_wt_o(wt),
        .events_rp_i(rp),
        .events_da_o(da),
        .level_o    (level),
        .full_o     (full),
        .empty_o    (empty)
`ifdef SOC_EVT_BUS_TX_STALL_CNT_EN
        ,
        .stall_cnt_o(stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [7:0]  rp;
        logic [3:0]  ready;
        logic [7:0]  wt;
        logic [63:0] da;
        logic [3:0]  lvl;
        logic        full;
        logic        empty;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reader is reset in the same window; inputs are driven from a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        valid = '0;
        data  = '0;
        rp    = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int acc;

        // inputs applied before the edge; expected state is what is visible before that edge
        tbl[0] = '{4'b0010, 32'h0000_5A00, 8'h00, 4'b0010, 8'h00, 64'h0,                 4'd0, 1'b0, 1'b1};
        tbl[1] = '{4'b0000, 32'h0000_0000, 8'h00, 4'b0000, 8'h01, 64'h5A,                4'd1, 1'b0, 1'b0};
        tbl[2] = '{4'b1111, 32'h1312_1110, 8'h01, 4'b0100, 8'h01, 64'h5A,                4'd1, 1'b0, 1'b0};
        tbl[3] = '{4'b1111, 32'h1312_1110, 8'h03, 4'b1000, 8'h03, 64'h125A,              4'd2, 1'b0, 1'b0};
        tbl[4] = '{4'b1111, 32'h1312_1110, 8'h07, 4'b0001, 8'h07, 64'h13125A,            4'd2, 1'b0, 1'b0};
        tbl[5] = '{4'b1111, 32'h1312_1110, 8'h0F, 4'b0010, 8'h0F, 64'h1013125A,          4'd2, 1'b0, 1'b0};
        tbl[6] = '{4'b1111, 32'h1312_1110, 8'h1F, 4'b0100, 8'h1F, 64'h111013125A,        4'd2, 1'b0, 1'b0};
        tbl[7] = '{4'b0000, 32'h1312_1110, 8'h1F, 4'b0000, 8'h3F, 64'h12111013125A,      4'd2, 1'b0, 1'b0};
        tbl[8] = '{4'b0000, 32'h0000_0000, 8'h1F, 4'b0000, 8'h3F, 64'h12111013125A,      4'd1, 1'b0, 1'b0};

        rst_n = 1'b0;
        valid = '0;
        data  = '0;
        rp    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset ready", ready, 4'b0000);
        chk("reset wt", wt, 8'h00);
        chk("reset da", da, 64'h0);
        chk("reset level", level, 4'd0);
        chk("reset full", full, 1'b0);
        chk("reset empty", empty, 1'b1);

        // single event, then round-robin with an immediately acking reader
        for (int i = 0; i < 9; i++) begin
            valid = tbl[i].valid;
            data  = tbl[i].data;
            rp    = tbl[i].rp;
            #1;
            chk($sformatf("row%0d ready", i), ready, tbl[i].ready);
            chk($sformatf("row%0d wt", i), wt, tbl[i].wt);
            chk($sformatf("row%0d da", i), da, tbl[i].da);
            chk($sformatf("row%0d level", i), level, tbl[i].lvl);
            chk($sformatf("row%0d full", i), full, tbl[i].full);
            chk($sformatf("row%0d empty", i), empty, tbl[i].empty);
            @(negedge clk);
        end

        // fill with a silent reader, then release slot 0
        do_reset();
        acc   = 0;
        valid = 4'b0001;
        data  = 32'h30;
        for (int c = 0; c < 20 && acc < 8; c++) begin
            #1;
            if (ready == 4'b0001) begin
                acc++;
            end
            @(negedge clk);
            data = 32'h30 + acc;
        end
        chk("fill accepts", acc, 8);
        #1;
        chk("fill full", full, 1'b1);
        chk("fill level", level, 4'd8);
        chk("fill ready", ready, 4'b0000);
        chk("fill wt", wt, 8'hFF);
        chk("fill da", da, 64'h3736353433323130);
        rp = 8'h01;
        @(negedge clk);
        #1;
        chk("release +1 full", full, 1'b1);
        @(negedge clk);
        data = 32'h40;
        #1;
        chk("release +2 full", full, 1'b0);
        chk("release +2 ready", ready, 4'b0001);
        chk("release +2 level", level, 4'd7);
        @(negedge clk);
        #1;
        chk("rewrite wt", wt, 8'hFE);
        chk("rewrite slot0", da[7:0], 8'h40);
        chk("rewrite level", level, 4'd8);
        chk("rewrite full", full, 1'b1);

        // accept and release on the same edge at level 3
        do_reset();
        valid = 4'b1000;
        data  = 32'h5500_0000;
        repeat (3) @(negedge clk);
        valid = '0;
        #1;
        chk("same-edge pre level", level, 4'd3);
        chk("same-edge pre wt", wt, 8'h07);
        rp = 8'h01;
        @(negedge clk);
        valid = 4'b1000;
        #1;
        chk("same-edge ready", ready, 4'b1000);
        chk("same-edge mid level", level, 4'd3);
        @(negedge clk);
        valid = '0;
        #1;
        chk("same-edge level", level, 4'd3);
        chk("same-edge wt", wt, 8'h0F);

        // reset with level 5 discards everything
        valid = 4'b1000;
        repeat (2) @(negedge clk);
        valid = '0;
        #1;
        chk("pre-reset level", level, 4'd5);
        do_reset();
        #1;
        chk("mid-reset wt", wt, 8'h00);
        chk("mid-reset level", level, 4'd0);
        chk("mid-reset empty", empty, 1'b1);
        chk("mid-reset da", da, 64'h0);
        valid = 4'b0010;
        data  = 32'h0000_7700;
        #1;
        chk("post-reset ready", ready, 4'b0010);
        @(negedge clk);
        valid = '0;
        #1;
        chk("post-reset wt", wt, 8'h01);
        chk("post-reset da", da, 64'h77);
        chk("post-reset level", level, 4'd1);

`ifdef SOC_EVT_BUS_TX_STALL_CNT_EN
        do_reset();
        valid = 4'b0001;
        data  = 32'h30;
        repeat (8) @(negedge clk);
        valid = '0;
        #1;
        chk("stall full", full, 1'b1);
        chk("stall start", stall, 16'd0);
        valid = 4'b0100;
        repeat (10) @(negedge clk);
        valid = '0;
        #1;
        chk("stall ten", stall, 16'd10);
        valid = 4'b0100;
        repeat (70000) @(negedge clk);
        valid = '0;
        #1;
        chk("stall saturate", stall, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soc_evt_bus_tx.md
Name: soc_evt_bus_tx

Overview:
Parametrised multi-channel transmitter for the SoC-to-cluster event bus, next generation of the single-source event path.
- Arbitrates N_CHAN event sources round-robin and writes event IDs into a BUFFER_WIDTH-slot buffer.
- Publishes each slot through a per-slot toggle write-token; the cluster side acknowledges through a per-slot toggle read-pointer.
- Sits in the SoC domain between the FC/peripheral event sources and the cluster event unit.

Parameters:
N_CHAN, 4, number of event source channels (>=1)
EVNT_WIDTH, 8, width of one event ID
BUFFER_WIDTH, 8, number of buffer slots and token bits (>=2)
LVL_W, $clog2(BUFFER_WIDTH+1), width of fill-level output

Ports:
clk_i  in  1  SoC clock
rst_ni  in  1  synchronous active-low reset
evt_valid_i  in  N_CHAN  per-channel event request
evt_data_i  in  N_CHAN*EVNT_WIDTH  per-channel event ID; channel c at [c*EVNT_WIDTH +: EVNT_WIDTH]
evt_ready_o  out  N_CHAN  per-channel accept, one-hot or zero
events_wt_o  out  BUFFER_WIDTH  per-slot write-token toggles
events_rp_i  in  BUFFER_WIDTH  per-slot read-pointer toggles from the reader; may be asynchronous
events_da_o  out  BUFFER_WIDTH*EVNT_WIDTH  slot data; slot s at [s*EVNT_WIDTH +: EVNT_WIDTH]
level_o  out  LVL_W  number of occupied slots
full_o  out  1  slot at write index occupied
empty_o  out  1  no slot occupied

Interface: one clock (clk_i); reset rst_ni is synchronous and active-low.

Behaviour:
- Reset (rst_ni low at a rising edge): clear all state.
  - events_wt_o, events_da_o, write index, RR pointer and rp synchroniser all reset to 0.
  - Resulting outputs: level_o=0, full_o=0, empty_o=1, evt_ready_o=0.
  - Reset mid-operation discards buffered events. The reader must be reset in the same window; tokens restart at 0.
- rp synchroniser: two flops per bit; rp_s = second stage. Latency from events_rp_i to rp_s is 2 cycles.
- Occupancy:
  - slot s occupied iff events_wt_o[s] != rp_s[s]
  - level_o = popcount(events_wt_o ^ rp_s)
  - full_o = occupied(wr_idx)
  - empty_o = (level_o==0)
  - All three are combinational from registers.
- Arbitration (combinational):
  - If !full_o, grant g = first channel with evt_valid_i set, searching from rr_ptr upward with wrap.
  - evt_ready_o[g]=1, all other bits 0.
  - If full_o or no valid, evt_ready_o=0.
- Accept (valid&ready on channel g) at rising edge:
  - slot wr_idx data <= channel g data
  - events_wt_o[wr_idx] toggles
  - wr_idx <= (wr_idx==BUFFER_WIDTH-1) ? 0 : wr_idx+1
  - rr_ptr <= (g==N_CHAN-1) ? 0 : g+1
  - Data and token update on the same edge; the reader's 2-flop token sync guarantees data stability.
- Throughput/latency:
  - At most one event per cycle.
  - Event visible on events_wt_o/events_da_o 1 cycle after the accept.
  - A freed slot is visible to the writer 2 cycles after the events_rp_i toggle.
- Slot ordering: slots are written strictly in index order 0..BUFFER_WIDTH-1, wrapping. Reader consumes in the same order.
- Full: writes stall (ready=0) until rp_s[wr_idx] matches; no event is dropped or overwritten.
- Simultaneous accept and rp_s release on the same edge: both applied; level_o unchanged.
- Unaccepted sources must hold valid/data stable (valid/ready rule); the block does not latch unaccepted requests.
- rr_ptr changes only on accept.

Optional Feature:
Macro SOC_EVT_BUS_TX_STALL_CNT_EN.
- Defined: adds output stall_cnt_o (16 bits).
  - Increments every cycle with |evt_valid_i && full_o.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then ch1 valid with data 8'h5A for one cycle, reader idle -> evt_ready_o=4'b0010; next cycle events_wt_o=8'h01, slot0 data=8'h5A, level_o=1, empty_o=0.
- All 4 channels valid continuously (data 0x10..0x13), reader acks each slot immediately -> grants in order 0,1,2,3,0,...; slots 0..7 hold 10,11,12,13,10,11,12,13.
- Reader never acks, ch0 valid constantly -> 8 accepts, then full_o=1, level_o=8, ready=0. Toggle events_rp_i[0] -> full_o drops exactly 2 cycles later; next accept writes slot 0 and wt[0] returns to 0.
- Same-edge accept and rp_s release with level_o=3 -> level_o stays 3.
- Reset asserted with level_o=5 -> next cycle events_wt_o=0, level_o=0, wr_idx=0; next accept lands in slot 0.
- With SOC_EVT_BUS_TX_STALL_CNT_EN: buffer full, ch2 valid for 10 cycles -> stall_cnt_o=10. Force 70000 stall cycles -> stall_cnt_o=16'hFFFF.
